// File: rtl/friscv_cache_line_loader.sv
`default_nettype none
// ============================================================================
// Module   : friscv_cache_line_loader
// Purpose  : Memory-side loader of the instruction cache. Takes cache-miss
//            requests from the block fetcher and issues single-beat AXI4 line
//            reads. Each returned line is written into the cache blocks and
//            block_fill is pulsed so the fetcher replays the missed fetch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: LOADER_DEDUP_EN
//   Defined   : a miss for the line most recently accepted, while that line is
//               still in flight and no flush has happened since, is accepted
//               without a new AR; the pending fill serves it.
//   Undefined : every accepted miss issues its own AR.
// ----------------------------------------------------------------------------
// Ports
//   aclk, aresetn, srst        clock, async active-low reset, sync reset
//   flush_reqs, flush_blocks   drop every in-flight request
//   miss_valid/ready/addr/prot miss request channel from the fetcher
//   ar*                        AXI4 read address channel (single beat, fixed ID)
//   r*                         AXI4 read data channel (rready held high)
//   cache_wen/waddr/wdata      line write into the cache blocks
//   block_fill                 one-cycle pulse when a line is written
//   load_err                   one-cycle pulse when a read returns rresp!=OKAY
// ============================================================================
module friscv_cache_line_loader #(
   parameter int                    OSTDREQ_NUM = 4,
   parameter int                    AXI_ADDR_W  = 32,
   parameter int                    AXI_ID_W    = 8,
   parameter logic [AXI_ID_W-1:0]   AXI_ID_MASK = 'h20,
   parameter int                    AXI_DATA_W  = 128
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  flush_reqs,
   input  logic                  flush_blocks,
   // miss request from the block fetcher
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [AXI_ADDR_W-1:0] miss_addr,
   input  logic [2:0]            miss_prot,
   // AXI4 read address channel
   output logic                  arvalid,
   input  logic                  arready,
   output logic [AXI_ADDR_W-1:0] araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [2:0]            arprot,
   output logic [AXI_ID_W-1:0]   arid,
   // AXI4 read data channel
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [AXI_ID_W-1:0]   rid,
   input  logic [1:0]            rresp,
   input  logic [AXI_DATA_W-1:0] rdata,
   input  logic                  rlast,
   // cache blocks write port
   output logic                  cache_wen,
   output logic [AXI_ADDR_W-1:0] cache_waddr,
   output logic [AXI_DATA_W-1:0] cache_wdata,
   output logic                  block_fill,
   output logic                  load_err
);

   localparam int OFF_W = $clog2(AXI_DATA_W/8);
   localparam int CNT_W = $clog2(OSTDREQ_NUM+1);
   localparam int PTR_W = (OSTDREQ_NUM > 1) ? $clog2(OSTDREQ_NUM) : 1;
   localparam logic [AXI_ADDR_W-1:0] LINE_MASK = {{(AXI_ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
   localparam logic [2:0] AR_SIZE  = 3'(OFF_W);
   localparam logic [1:0] AR_INCR  = 2'b01;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0]      ostd_q,    ostd_d;     // accepted, not yet answered
   logic [CNT_W-1:0]      drop_q,    drop_d;     // answers still to discard
   logic [PTR_W-1:0]      wptr_q,    wptr_d;
   logic [PTR_W-1:0]      rptr_q,    rptr_d;
   logic                  arvalid_q, arvalid_d;
   logic [AXI_ADDR_W-1:0] araddr_q,  araddr_d;
   logic [2:0]            arprot_q,  arprot_d;
   logic                  rready_q,  rready_d;
   logic                  wen_q,     wen_d;
   logic [AXI_ADDR_W-1:0] waddr_q,   waddr_d;
   logic [AXI_DATA_W-1:0] wdata_q,   wdata_d;
   logic                  fill_q,    fill_d;
   logic                  err_q,     err_d;

   // Line addresses of in-flight reads, in issue order (responses are in order)
   logic [AXI_ADDR_W-1:0] fifo_mem [OSTDREQ_NUM];

   logic                  w_flush;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_dedup;
   logic                  w_push;
   logic                  w_rhs;
   logic                  w_pop;
   logic [AXI_ADDR_W-1:0] w_line;
   logic [AXI_ADDR_W-1:0] w_head;
   logic                  w_unused;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(OSTDREQ_NUM-1))
         return '0;
      return p + PTR_W'(1);
   endfunction

   // -------------------------------------------------------------------------
   // Handshakes
   // -------------------------------------------------------------------------
   assign w_flush = flush_reqs | flush_blocks;
   assign w_line  = miss_addr & LINE_MASK;
   assign w_head  = fifo_mem[rptr_q];

   // rready_q doubles as the "out of reset" flag so nothing is accepted in reset.
   // A new miss needs the AR slot free, or freeing in this very cycle.
   assign w_ready  = rready_q & ~srst & ~w_flush &
                     (ostd_q < CNT_W'(OSTDREQ_NUM)) &
                     (~arvalid_q | arready);
   assign w_accept = miss_valid & w_ready;
   assign w_push   = w_accept & ~w_dedup;

   // A beat with nothing outstanding is consumed and ignored.
   assign w_rhs    = rvalid & rready_q;
   assign w_pop    = w_rhs & (ostd_q != '0);

   // Single ID, single beat: the response fields below carry no information.
   assign w_unused = ^{rid, rlast};

`ifdef LOADER_DEDUP_EN
   logic [AXI_ADDR_W-1:0] last_line_q, last_line_d;
   logic                  last_vld_q,  last_vld_d;

   // The last accepted line is the newest FIFO entry, so while anything is
   // outstanding (and no flush has marked it for discard) its fill is pending.
   assign w_dedup = last_vld_q & (ostd_q != '0) & (w_line == last_line_q);

   always_comb begin
      last_line_d = last_line_q;
      last_vld_d  = last_vld_q;
      if (srst || w_flush) begin
         last_vld_d = 1'b0;
      end else if (w_push) begin
         last_line_d = w_line;
         last_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         last_line_q <= '0;
         last_vld_q  <= 1'b0;
      end else begin
         last_line_q <= last_line_d;
         last_vld_q  <= last_vld_d;
      end
   end
`else
   assign w_dedup = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next state
   // -------------------------------------------------------------------------
   always_comb begin
      ostd_d    = ostd_q;
      drop_d    = drop_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arprot_d  = arprot_q;
      rready_d  = 1'b1;
      wen_d     = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      fill_d    = 1'b0;
      err_d     = 1'b0;

      if (srst) begin
         ostd_d    = '0;
         drop_d    = '0;
         wptr_d    = '0;
         rptr_d    = '0;
         arvalid_d = 1'b0;
         araddr_d  = '0;
         arprot_d  = '0;
         rready_d  = 1'b0;
         waddr_d   = '0;
         wdata_d   = '0;
      end else begin
         // AR channel: held until arready, then possibly reloaded same cycle
         if (arvalid_q && arready)
            arvalid_d = 1'b0;
         if (w_push) begin
            arvalid_d = 1'b1;
            araddr_d  = w_line;
            arprot_d  = miss_prot;
            wptr_d    = ptr_inc(wptr_q);
         end

         // R channel: a beat arriving in a flush cycle is discarded as well
         if (w_pop) begin
            rptr_d = ptr_inc(rptr_q);
            if (!w_flush && drop_q == '0) begin
               if (rresp == 2'b00) begin
                  wen_d   = 1'b1;
                  fill_d  = 1'b1;
                  waddr_d = w_head;
                  wdata_d = rdata;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end

         // push is blocked at the limit and pop needs ostd>0: no wrap possible
         ostd_d = ostd_q + CNT_W'(w_push) - CNT_W'(w_pop);

         // A flush marks every in-flight line (minus the one retiring now) for discard
         if (w_flush)
            drop_d = ostd_q - CNT_W'(w_pop);
         else if (w_pop && drop_q != '0)
            drop_d = drop_q - CNT_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ostd_q    <= '0;
         drop_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arprot_q  <= '0;
         rready_q  <= 1'b0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         fill_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ostd_q    <= ostd_d;
         drop_q    <= drop_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arprot_q  <= arprot_d;
         rready_q  <= rready_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         fill_q    <= fill_d;
         err_q     <= err_d;
      end
   end

   // Address storage only; occupancy is tracked by ostd_q and the pointers
   always_ff @(posedge aclk) begin
      if (w_push)
         fifo_mem[wptr_q] <= w_line;
   end

   // -------------------------------------------------------------------------
   // Outputs (constant AR fields are masked so every output is 0 in reset)
   // -------------------------------------------------------------------------
   assign miss_ready  = w_ready;
   assign arvalid     = arvalid_q;
   assign araddr      = araddr_q;
   assign arlen       = 8'd0;
   assign arsize      = arvalid_q ? AR_SIZE : 3'd0;
   assign arburst     = arvalid_q ? AR_INCR : 2'b00;
   assign arprot      = arprot_q;
   assign arid        = arvalid_q ? AXI_ID_MASK : '0;
   assign rready      = rready_q;
   assign cache_wen   = wen_q;
   assign cache_waddr = waddr_q;
   assign cache_wdata = wdata_q;
   assign block_fill  = fill_q;
   assign load_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_friscv_cache_line_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_friscv_cache_line_loader
// Purpose  : Self-checking bench for friscv_cache_line_loader. A queue-based
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_friscv_cache_line_loader;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int IW = 8;
   localparam int DW = 128;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b1;
   logic          srst = 1'b0;
   logic          flush_reqs = 1'b0;
   logic          flush_blocks = 1'b0;
   logic          miss_valid = 1'b0;
   logic          miss_ready;
   logic [AW-1:0] miss_addr = '0;
   logic [2:0]    miss_prot = '0;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [2:0]    arprot;
   logic [IW-1:0] arid;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [IW-1:0] rid = 8'h20;
   logic [1:0]    rresp = 2'b00;
   logic [DW-1:0] rdata = '0;
   logic          rlast = 1'b1;
   logic          cache_wen;
   logic [AW-1:0] cache_waddr;
   logic [DW-1:0] cache_wdata;
   logic          block_fill;
   logic          load_err;

   always #5 aclk = ~aclk;

   friscv_cache_line_loader #(
      .OSTDREQ_NUM (N),
      .AXI_ADDR_W  (AW),
      .AXI_ID_W    (IW),
      .AXI_ID_MASK (8'h20),
      .AXI_DATA_W  (DW)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .srst         (srst),
      .flush_reqs   (flush_reqs),
      .flush_blocks (flush_blocks),
      .miss_valid   (miss_valid),
      .miss_ready   (miss_ready),
      .miss_addr    (miss_addr),
      .miss_prot    (miss_prot),
      .arvalid      (arvalid),
      .arready      (arready),
      .araddr       (araddr),
      .arlen        (arlen),
      .arsize       (arsize),
      .arburst      (arburst),
      .arprot       (arprot),
      .arid         (arid),
      .rvalid       (rvalid),
      .rready       (rready),
      .rid          (rid),
      .rresp        (rresp),
      .rdata        (rdata),
      .rlast        (rlast),
      .cache_wen    (cache_wen),
      .cache_waddr  (cache_waddr),
      .cache_wdata  (cache_wdata),
      .block_fill   (block_fill),
      .load_err     (load_err)
   );

   // ------------------------------------------------------------------------
   // Check bookkeeping
   // ------------------------------------------------------------------------
   int n_total = 0;
   int n_pass  = 0;
   bit cmp_en  = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
   endtask

   task automatic tmo(input string nm);
      n_total++;
      $display("FAIL %s: timed out waiting @%0t", nm, $time);
   endtask

   // ------------------------------------------------------------------------
   // Model: a queue of in-flight lines in issue order. A flush tags every
   // queued line as discarded; a response retires the head entry.
   // ------------------------------------------------------------------------
   typedef struct {
      logic [31:0] line;
      bit          disc;
   } ent_t;

   ent_t         mq[$];
   bit           m_run = 1'b0;
   bit           m_arv = 1'b0;
   logic [31:0]  m_araddr = '0;
   logic [2:0]   m_arprot = '0;
   logic [31:0]  m_last = '0;
   bit           m_lastv = 1'b0;
   bit           m_wen = 1'b0;
   bit           m_fill = 1'b0;
   bit           m_err = 1'b0;
   logic [31:0]  m_waddr = '0;
   logic [127:0] m_wdata = '0;

   function automatic bit exp_ready();
      return m_run && !srst && !(flush_reqs || flush_blocks) &&
             (mq.size() < N) && (!m_arv || arready);
   endfunction

   always @(posedge aclk or negedge aresetn) begin : mdl
      bit          acc;
      bit          fl;
      bit          dd;
      int          sz;
      ent_t        e;
      logic [31:0] line;
      if (!aresetn || srst) begin
         mq.delete();
         m_run = 0; m_arv = 0; m_araddr = '0; m_arprot = '0;
         m_lastv = 0; m_wen = 0; m_fill = 0; m_err = 0;
         m_waddr = '0; m_wdata = '0;
      end else begin
         sz  = mq.size();
         acc = miss_valid && exp_ready();
         fl  = flush_reqs || flush_blocks;
         m_wen = 0; m_fill = 0; m_err = 0;
         if (rvalid && m_run && sz > 0) begin
            e = mq.pop_front();
            if (!e.disc && !fl) begin
               if (rresp == 2'b00) begin
                  m_wen = 1; m_fill = 1; m_waddr = e.line; m_wdata = rdata;
               end else begin
                  m_err = 1;
               end
            end
         end
         if (fl) begin
            foreach (mq[i]) mq[i].disc = 1;
            m_lastv = 0;
         end
         if (m_arv && arready) m_arv = 0;
         if (acc) begin
            line = {miss_addr[31:4], 4'h0};
            dd = 0;
`ifdef LOADER_DEDUP_EN
            dd = m_lastv && (sz > 0) && (line == m_last);
`endif
            if (!dd) begin
               mq.push_back('{line: line, disc: 1'b0});
               m_arv = 1; m_araddr = line; m_arprot = miss_prot;
               m_last = line; m_lastv = 1;
            end
         end
         m_run = 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge aclk) begin
      if (cmp_en) begin
         chk("miss_ready", miss_ready, exp_ready());
         chk("arvalid", arvalid, m_arv);
         if (m_arv) begin
            chk("araddr", araddr, m_araddr);
            chk("arprot", arprot, m_arprot);
         end
         chk("arlen", arlen, 0);
         chk("arsize", arsize, m_arv ? 4 : 0);
         chk("arburst", arburst, m_arv ? 1 : 0);
         chk("arid", arid, m_arv ? 8'h20 : 8'h00);
         chk("rready", rready, m_run);
         chk("cache_wen", cache_wen, m_wen);
         chk("block_fill", block_fill, m_fill);
         chk("load_err", load_err, m_err);
         if (m_wen) begin
            chk("cache_waddr", cache_waddr, m_waddr);
            chk("cache_wdata", cache_wdata, m_wdata);
         end
      end
   end

   // Event counters for the dedup scenario
   int n_ar   = 0;
   int n_fill = 0;
   always @(negedge aclk) begin
      if (aresetn && arvalid && arready) n_ar++;
      if (block_fill) n_fill++;
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (all start and end 1ns after a rising edge)
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [127:0] dat(input int k);
      return {4{32'hA5A5_0000 + 32'(k)}};
   endfunction

   task automatic do_miss(input logic [31:0] a, input logic [2:0] p);
      bit ok;
      ok = 0;
      miss_valid = 1; miss_addr = a; miss_prot = p;
      for (int k = 0; k < 20; k++) begin
         @(negedge aclk);
         if (miss_ready) begin ok = 1; break; end
      end
      if (!ok) tmo("miss accept");
      tick();
      miss_valid = 0;
   endtask

   task automatic send_r_chk(input logic [127:0] d, input logic [1:0] resp, input bit fl,
                             input bit exp_wen, input logic [31:0] exp_addr, input bit exp_err);
      rvalid = 1; rdata = d; rresp = resp; rlast = 1; flush_blocks = fl;
      tick();
      rvalid = 0; flush_blocks = 0;
      @(negedge aclk);
      chk("lit wen", cache_wen, exp_wen);
      chk("lit fill", block_fill, exp_wen);
      chk("lit err", load_err, exp_err);
      if (exp_wen) begin
         chk("lit waddr", cache_waddr, exp_addr);
         chk("lit wdata", cache_wdata, d);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int a0, f0, exp_n;
      // ---------------- reset -------------------------------------------
      #2 aresetn = 0;
      cmp_en = 1;
      @(negedge aclk);
      chk("rst arvalid", arvalid, 0);
      chk("rst miss_ready", miss_ready, 0);
      chk("rst rready", rready, 0);
      chk("rst araddr", araddr, 0);
      chk("rst cache_wen", cache_wen, 0);
      tick(); tick();
      aresetn = 1;
      tick();
      arready = 1;

      // ---------------- 1: single miss ---------------------------------
      do_miss(32'h1004, 3'b010);
      @(negedge aclk);
      chk("t1 arvalid", arvalid, 1);
      chk("t1 araddr", araddr, 32'h1000);
      chk("t1 arlen", arlen, 0);
      chk("t1 arsize", arsize, 4);
      chk("t1 arburst", arburst, 1);
      chk("t1 arid", arid, 8'h20);
      chk("t1 arprot", arprot, 3'b010);
      tick();
      send_r_chk(dat(1), 2'b00, 0, 1, 32'h1000, 0);
      @(negedge aclk);
      chk("t1 fill one cycle", block_fill, 0);
      tick();

      // ---------------- 2: outstanding limit ----------------------------
      arready = 0;
      do_miss(32'h4000, 0);
      miss_valid = 1; miss_addr = 32'h5000;
      @(negedge aclk);
      chk("t2 held ar blocks", miss_ready, 0);
      tick();
      @(negedge aclk);
      chk("t2 held ar blocks 2", miss_ready, 0);
      tick();
      arready = 1;
      do_miss(32'h5000, 0);
      do_miss(32'h6000, 0);
      do_miss(32'h7000, 0);
      miss_valid = 1; miss_addr = 32'h8000;
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("t2 full", miss_ready, 0);
         tick();
      end
      send_r_chk(dat(4), 2'b00, 0, 1, 32'h4000, 0);
      miss_valid = 0;
      @(negedge aclk);
      chk("t2 fifth ar", araddr, 32'h8000);
      tick();
      send_r_chk(dat(5), 2'b00, 0, 1, 32'h5000, 0);
      send_r_chk(dat(6), 2'b00, 0, 1, 32'h6000, 0);
      send_r_chk(dat(7), 2'b00, 0, 1, 32'h7000, 0);
      send_r_chk(dat(8), 2'b00, 0, 1, 32'h8000, 0);

      // ---------------- 3: flush ----------------------------------------
      do_miss(32'h9000, 0);
      do_miss(32'hA000, 0);
      tick(); tick();
      flush_reqs = 1;
      tick();
      flush_reqs = 0;
      send_r_chk(dat(9), 2'b00, 0, 0, 0, 0);
      send_r_chk(dat(10), 2'b00, 0, 0, 0, 0);
      do_miss(32'h2000, 0);
      tick();
      send_r_chk(dat(2), 2'b00, 0, 1, 32'h2000, 0);
      // flush in the same cycle as a returning beat
      do_miss(32'hE000, 0);
      do_miss(32'hF000, 0);
      tick();
      send_r_chk(dat(14), 2'b00, 1, 0, 0, 0);
      send_r_chk(dat(15), 2'b00, 0, 0, 0, 0);
      // beat with nothing outstanding
      send_r_chk(dat(16), 2'b00, 0, 0, 0, 0);

      // ---------------- 4: error response -------------------------------
      do_miss(32'hB010, 3'b001);
      tick();
      send_r_chk(dat(11), 2'b10, 0, 0, 0, 1);
      @(negedge aclk);
      chk("t4 ready after err", miss_ready, 1);
      tick();

      // ---------------- 5: same-line misses -----------------------------
`ifdef LOADER_DEDUP_EN
      exp_n = 1;
`else
      exp_n = 2;
`endif
      a0 = n_ar;
      do_miss(32'h3000, 0);
      do_miss(32'h3008, 0);
      tick(); tick(); tick();
      chk("t5 ar count", 32'(n_ar - a0), 32'(exp_n));
      f0 = n_fill;
      send_r_chk(dat(3), 2'b00, 0, 1, 32'h3000, 0);
      if (exp_n == 2) send_r_chk(dat(13), 2'b00, 0, 1, 32'h3000, 0);
      chk("t5 fill count", 32'(n_fill - f0), 32'(exp_n));

      // ---------------- 6: async reset mid-burst ------------------------
      arready = 0;
      do_miss(32'hC000, 0);
      @(negedge aclk);
      chk("t6 arvalid before rst", arvalid, 1);
      @(posedge aclk);
      #3 aresetn = 0;
      @(negedge aclk);
      chk("t6 rst arvalid", arvalid, 0);
      chk("t6 rst araddr", araddr, 0);
      chk("t6 rst miss_ready", miss_ready, 0);
      chk("t6 rst rready", rready, 0);
      tick(); tick();
      aresetn = 1;
      arready = 1;
      tick();
      do_miss(32'hD000, 0);
      @(negedge aclk);
      chk("t6 clean ar", araddr, 32'hD000);
      tick();
      send_r_chk(dat(12), 2'b00, 0, 1, 32'hD000, 0);

      // ---------------- synchronous reset -------------------------------
      arready = 0;
      do_miss(32'h7770, 0);
      srst = 1;
      tick();
      srst = 0;
      @(negedge aclk);
      chk("srst arvalid", arvalid, 0);
      chk("srst rready", rready, 0);
      tick(); tick();
      arready = 1;
      do_miss(32'h6660, 0);
      tick();
      send_r_chk(dat(17), 2'b00, 0, 1, 32'h6660, 0);

      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
